// File: rtl/mips_muldiv_unit_if.sv
// Operand/result bundle between the datapath controller and the iterative
// multiply/divide unit.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, then a sign-fix cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mips_muldiv_unit_if.slave  io_bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               w_busy;

  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic               r_isDiv;
  logic               r_negLo;
  logic               r_negHi;
  logic               r_divZero;
  logic               r_done;
  logic               r_divByZero;

  logic               w_signed;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;

  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH-1:0]   w_mulHiNext;
  logic [WIDTH-1:0]   w_mulLoNext;

  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_divHiNext;
  logic [WIDTH-1:0]   w_divLoNext;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Signed ops iterate on magnitudes; signs are restored in FIX.
  assign w_signed = ~io_bus.op[0];
  assign w_aNeg   = w_signed & io_bus.a[WIDTH-1];
  assign w_bNeg   = w_signed & io_bus.b[WIDTH-1];
  assign w_aMag   = w_aNeg ? -io_bus.a : io_bus.a;
  assign w_bMag   = w_bNeg ? -io_bus.b : io_bus.b;

  assign w_mulSum    = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : '0);
  assign w_mulHiNext = w_mulSum[WIDTH:1];
  assign w_mulLoNext = {w_mulSum[0], r_accLo[WIDTH-1:1]};

  // The partial remainder is always below the divisor, so the borrow bit
  // of the trial subtraction alone decides the quotient bit.
  assign w_shifted   = {r_accHi, r_accLo[WIDTH-1]};
  assign w_diff      = w_shifted - {1'b0, r_opB};
  assign w_ge        = ~w_diff[WIDTH];
  assign w_divHiNext = w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign w_divLoNext = {r_accLo[WIDTH-2:0], w_ge};

  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodFix = r_negLo ? -w_prod : w_prod;
  assign w_quot    = r_negLo ? -r_accLo : r_accLo;
  assign w_rem     = r_negHi ? -r_accHi : r_accHi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.start && !io_bus.op[2]) w_nextState = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) w_nextState = FIX;
      end
      FIX: begin
        w_busy      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_accHi     <= '0;
      r_accLo     <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_isDiv     <= 1'b0;
      r_negLo     <= 1'b0;
      r_negHi     <= 1'b0;
      r_divZero   <= 1'b0;
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            case (io_bus.op)
              3'b100: begin
                r_hi   <= io_bus.a;
                r_done <= 1'b1;
              end
              3'b101: begin
                r_lo   <= io_bus.a;
                r_done <= 1'b1;
              end
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_count   <= '0;
                r_isDiv   <= io_bus.op[1];
                r_opA     <= io_bus.a;
                r_opB     <= w_bMag;
                r_accHi   <= '0;
                r_accLo   <= w_aMag;
                r_negLo   <= w_aNeg ^ w_bNeg;
                r_negHi   <= w_aNeg;
                r_divZero <= io_bus.op[1] && (io_bus.b == '0);
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          r_count <= r_count + 1'b1;
          if (r_isDiv) begin
            r_accHi <= w_divHiNext;
            r_accLo <= w_divLoNext;
          end else begin
            r_accHi <= w_mulHiNext;
            r_accLo <= w_mulLoNext;
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_isDiv) begin
            {r_hi, r_lo} <= w_prodFix;
          end else if (r_divZero) begin
            r_hi        <= r_opA;
            r_lo        <= '1;
            r_divByZero <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.busy        = w_busy;
  assign io_bus.done        = r_done;
  assign io_bus.div_by_zero = r_divByZero;
  assign io_bus.hi          = r_hi;
  assign io_bus.lo          = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit at WIDTH=32 (scoreboarded table)
// and WIDTH=8 (hand-written sequence).
module tb_mips_muldiv_unit;
  localparam int W  = 32;
  localparam int W8 = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    logic         expDbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           doneEdge;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycleCount = 0;
  exp_t sbQ[$];
  exp_t monExp;
  vec_t vecs[13];

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  mips_muldiv_unit_if #(.WIDTH(W))  bus ();
  mips_muldiv_unit_if #(.WIDTH(W8)) bus8 ();

  mips_muldiv_unit #(.WIDTH(W))  dut  (.clk(clk), .rst(rst), .io_bus(bus));
  mips_muldiv_unit #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .io_bus(bus8));

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every done pulse from the 32-bit unit must match the oldest
  // outstanding expectation, including the edge on which it appears.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected done=0 at edge %0d", cycleCount);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("hi", bus.hi, monExp.hi);
        checkOutput("lo", bus.lo, monExp.lo);
        checkOutput("div_by_zero", bus.div_by_zero, monExp.dbz);
        checkOutput("done_edge", cycleCount, monExp.doneEdge);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with
  // garbage on the operand lines to prove they were latched.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    if (v.op[2:1] != 2'b11) begin
      e.hi       = v.expHi;
      e.lo       = v.expLo;
      e.dbz      = v.expDbz;
      e.doneEdge = cycleCount + 1 + (v.op[2] ? 0 : W + 1);
      sbQ.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom_range(0, 7));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Waits for done while counting busy cycles; pokes a stray MTHI mid-run.
  task automatic waitDone(input logic [2:0] op);
    int busyCnt = 0;
    int n = 0;
    while (!bus.done && n < 200) begin
      if (bus.busy) busyCnt++;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
    checkOutput("busy_cycles", busyCnt, op[2] ? 0 : W + 1);
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] expHi,
                      input logic [7:0] expLo, input logic expDbz);
    int n = 0;
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    while (!bus8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, n, op[2] ? 0 : W8 + 1);
    checkOutput({name, "_hi"}, bus8.hi, expHi);
    checkOutput({name, "_lo"}, bus8.lo, expLo);
    checkOutput({name, "_dbz"}, bus8.div_by_zero, expDbz);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{3'b011, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[6]  = '{3'b100, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_000E, 1'b0};
    vecs[7]  = '{3'b101, 32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0};
    vecs[8]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[9]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{3'b011, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0};
    vecs[12] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.a      = '0;
    bus.b      = '0;
    bus8.start = 1'b0;
    bus8.op    = 3'b000;
    bus8.a     = '0;
    bus8.b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Each op is issued in the cycle its predecessor's done is high.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      waitDone(vecs[i].op);
    end

    applyStimulus('{3'b110, 32'h5555_5555, 32'h0000_0003, 32'h0, 32'h0, 1'b0});
    repeat (3) @(negedge clk);
    checkOutput("noop_hi", bus.hi, 32'hFFFF_FFF9);
    checkOutput("noop_lo", bus.lo, 32'hFFFF_FFFF);
    checkOutput("noop_busy", bus.busy, 0);

    // Reset mid-MULT: registers clear at once and no done follows.
    applyStimulus('{3'b000, 32'h0000_0009, 32'h0000_0009, 32'h0, 32'h51, 1'b0});
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_hi", bus.hi, 0);
    checkOutput("midrst_lo", bus.lo, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_done", bus.done, 0);
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("postrst_busy", bus.busy, 0);
    checkOutput("postrst_lo", bus.lo, 0);

    run8("w8_mult",  3'b000, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
    run8("w8_multu", 3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    run8("w8_div",   3'b010, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
    run8("w8_ovf",   3'b010, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    run8("w8_dbz",   3'b011, 8'h64, 8'h00, 8'h64, 8'hFF, 1'b1);
    run8("w8_divu",  3'b011, 8'h64, 8'h07, 8'h02, 8'h0E, 1'b0);
    run8("w8_mthi",  3'b100, 8'h12, 8'h00, 8'h12, 8'h0E, 1'b0);

    @(negedge clk);
    checkOutput("sb_empty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers. It extends the datapath ALU with the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO operations. It sits beside the ALU, takes RF_RD1/RF_RD2 as operands, and exposes HI/LO for MFHI/MFLO writeback. The controller stalls PC update while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be ≥4 and even.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  operation request; sampled on rising clk
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
a  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  high while a mul/div iteration is in progress
done  output  1  one-cycle pulse: HI/LO updated this cycle
div_by_zero  output  1  valid with done; high if DIV/DIVU had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. The in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- Accept: start=1 and state==IDLE at a rising edge. start in RUN/FIX is ignored; no queueing.
- Operand latch: a, b and op are latched at accept. Later changes to a/b/op do not affect the result.
- MTHI/MTLO: at the accept edge, hi<=a (or lo<=a); the other register holds. The FSM stays in IDLE, busy stays 0, and done=1 for the following cycle. op 11x: no state change, no done.
- MULT/MULTU/DIV/DIVU: at the accept edge, the FSM goes to RUN, busy=1, counter=0.
  - Signed ops convert operands to magnitudes and record the result signs.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge. After exactly WIDTH steps, the FSM goes to FIX.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - Set done=1 and busy=0 for the next cycle; return to IDLE.
  - Total latency: accept edge + WIDTH + 1 edges. For WIDTH=32, done is high in the cycle after the 34th edge counted from the accept edge.
- hi/lo hold their prior values throughout RUN/FIX until the FIX edge.
- A new start may be accepted in the same cycle that done is high (state is IDLE).
- Multiply: {hi,lo} = full 2·WIDTH-bit product. MULT is two's complement; MULTU is unsigned.
- Divide: lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b==0, DIV or DIVU): same latency, no hang. Result is lo=all ones, hi=a, div_by_zero=1 with done. div_by_zero=0 on every other done.
- Signed overflow (DIV with a=most-negative, b=−1): lo=most-negative, hi=0, div_by_zero=0.
- done is a single-cycle pulse; it is never high for two consecutive cycles from the same operation.

Test Plan:
- MULT, a=FFFFFFFD (−3), b=00000005 -> after 34 edges done=1, hi=FFFFFFFF, lo=FFFFFFF1. busy high for exactly 33 cycles; start pulses during busy ignored.
- MULTU, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV, a=FFFFFFF9 (−7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. Then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
- DIVU, a=00000064, b=0 -> done after 34 edges, lo=FFFFFFFF, hi=00000064, div_by_zero=1. Next DIVU 100/7 -> lo=0000000E, hi=00000002, div_by_zero=0.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on the next cycle -> hi=12345678, lo=9ABCDEF0, busy never asserted, done pulses once per op. Back-to-back MULT issued in the done cycle is accepted.
- Reset: assert rst 10 cycles into a MULT -> immediately hi=lo=0, busy=0, done=0, and no done pulse follows. Repeat all cases with WIDTH=8 (e.g. MULT 0xFD×0x05 -> hi=FF, lo=F1 after 10 edges).
